// File: rtl/key_conditioner.sv
// key_conditioner: per-key synchronizer, debouncer, edge pulses and auto-repeat
// for active-low raw pushbuttons. Every channel is a fully independent copy.
module key_conditioner #(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_down,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  localparam bit          RPT_EN = (REPEAT_DELAY != 0);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RPT_AT  = RW'(REPEAT_DELAY);
  // If REPEAT_PERIOD > REPEAT_DELAY this value is taken modulo 2^RW; adding
  // REPEAT_PERIOD then lands exactly on RPT_AT, so the spacing stays correct.
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;

  // Two-flop synchronizer on the raw keys; resets to released (1).
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    logic          down;
    logic          press;
    logic          release_p;
    logic          repeat_p;
    logic [DW-1:0] db_cnt;
    logic [RW-1:0] rpt_cnt;
    logic          sync_pressed;
    logic          mismatch;
    logic          flip;
    logic [RW-1:0] rpt_next;

    assign sync_pressed = ~sync2[i];
    assign mismatch     = (sync_pressed != down);
    assign flip         = mismatch && (db_cnt == DB_LAST);
    assign rpt_next     = rpt_cnt + RW'(1);

    // Debounce state, edge pulses and repeat counter for one key.
    always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
        db_cnt    <= '0;
        rpt_cnt   <= '0;
        down      <= 1'b0;
        press     <= 1'b0;
        release_p <= 1'b0;
        repeat_p  <= 1'b0;
      end else begin
        press     <= flip && !down;
        release_p <= flip && down;
        repeat_p  <= 1'b0;

        if (!mismatch || flip) begin
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end

        if (flip) begin
          down <= ~down;
        end

        // Press edge loads 0, release edge clears; neither may emit a repeat.
        if (!down || flip) begin
          rpt_cnt <= '0;
        end else if (RPT_EN) begin
          if (rpt_next == RPT_AT) begin
            repeat_p <= 1'b1;
            rpt_cnt  <= RPT_RELOAD;
          end else begin
            rpt_cnt <= rpt_next;
          end
        end
      end
    end

    assign key_down[i]    = down;
    assign key_press[i]   = press;
    assign key_release[i] = release_p;
    assign key_repeat[i]  = repeat_p;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: stimulus pushes hand-computed pulse
// events (edge number, pulse vectors, key_down after the edge); a monitor pops
// and compares on every cycle where an event is due or the DUT pulses.
module tb_key_conditioner;

  logic       CLOCK_50 = 1'b0;
  logic       RESET    = 1'b1;
  logic [3:0] KEY      = 4'b0000;
  logic [3:0] key_down;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_repeat;

  key_conditioner #(
    .N_KEYS          (4),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET       (RESET),
    .KEY         (KEY),
    .key_down    (key_down),
    .key_press   (key_press),
    .key_release (key_release),
    .key_repeat  (key_repeat)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Edge counter: after posedge n, cyc == n. rst_edge is RESET seen at that edge.
  int unsigned cyc      = 0;
  logic        rst_edge = 1'b0;
  always @(posedge CLOCK_50) begin
    cyc      <= cyc + 1;
    rst_edge <= RESET;
  end

  typedef struct {
    int unsigned cyc;
    logic [3:0]  press;
    logic [3:0]  rel;
    logic [3:0]  rpt;
    logic [3:0]  down;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        e;
  logic [3:0] exp_down = 4'b0000;
  int         total    = 0;
  int         passed   = 0;
  bit         done     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s at edge %0d: got %0h, required %0h", name, cyc, act, req);
  endtask

  task automatic push(input int unsigned c, input logic [3:0] p, input logic [3:0] r,
                      input logic [3:0] t, input logic [3:0] d);
    ev_t x;
    x.cyc = c; x.press = p; x.rel = r; x.rpt = t; x.down = d;
    exp_q.push_back(x);
  endtask

  // Wait until the negedge following posedge c; inputs driven here are first sampled at c+1.
  task automatic goto(input int unsigned c);
    while (cyc < c) @(negedge CLOCK_50);
  endtask

  // Monitor: compares away from the active edge.
  always @(negedge CLOCK_50) begin
    if (cyc >= 1 && !done) begin
      if (rst_edge) begin
        exp_down = 4'b0000;
        chk("reset_outputs", {16'h0, key_down, key_press, key_release, key_repeat}, 32'h0);
      end else begin
        while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          total++;
          $display("FAIL missing_event: no pulse at edge %0d, required press=%b rel=%b rpt=%b",
                   e.cyc, e.press, e.rel, e.rpt);
        end
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          exp_down = e.down;
          chk("key_press", key_press, e.press);
          chk("key_release", key_release, e.rel);
          chk("key_repeat", key_repeat, e.rpt);
        end else begin
          chk("no_pulse", {key_press, key_release, key_repeat}, 0);
        end
        chk("key_down", key_down, exp_down);
        chk("press_repeat_excl", key_press & key_repeat, 0);
        chk("press_release_excl", key_press & key_release, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got edge %0d, required < 400", cyc);
    $fatal(1);
  end

  initial begin
    // Reset with all keys held: edges 1..3 in reset, edge 4 is the first sample.
    goto(3);
    RESET = 1'b0;
    push(9, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
    goto(10);
    KEY = 4'b1111;
    push(16, 4'b0000, 4'b1111, 4'b0000, 4'b0000);

    // Clean press/release on key 0, held long enough for two repeats.
    goto(20);
    KEY = 4'b1110;
    push(26, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    push(36, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    push(41, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    goto(40);
    KEY = 4'b1111;
    // The would-be repeat at 46 coincides with the release and must be dropped.
    push(46, 4'b0000, 4'b0001, 4'b0000, 4'b0000);

    // Bounce on key 1: 2-cycle segments never complete debounce.
    goto(60);
    for (int i = 0; i < 15; i++) begin
      KEY[1] = (i % 2 == 0);
      goto(60 + 2 * (i + 1));
    end
    KEY[1] = 1'b0;
    push(96, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    goto(98);
    KEY[1] = 1'b1;
    push(104, 4'b0000, 4'b0010, 4'b0000, 4'b0000);

    // Auto-repeat on key 2.
    goto(120);
    KEY[2] = 1'b0;
    push(126, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    for (int k = 0; k < 6; k++) push(136 + 5 * k, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    goto(160);
    KEY[2] = 1'b1;
    push(166, 4'b0000, 4'b0100, 4'b0000, 4'b0000);

    // Simultaneous press of keys 3 and 0.
    goto(190);
    KEY = 4'b0110;
    push(196, 4'b1001, 4'b0000, 4'b0000, 4'b1001);
    goto(199);
    KEY = 4'b1111;
    push(205, 4'b0000, 4'b1001, 4'b0000, 4'b0000);

    // Reset mid-press on key 3: no release, fresh press after reset.
    goto(220);
    KEY[3] = 1'b0;
    push(226, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
    goto(227);
    RESET = 1'b1;
    goto(229);
    RESET = 1'b0;
    push(235, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
    goto(238);
    KEY[3] = 1'b1;
    push(244, 4'b0000, 4'b1000, 4'b0000, 4'b0000);

    goto(270);
    done = 1'b1;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
